// File: rtl/aes_inv_cipher_128.sv
// AES-128 iterative inverse cipher: forward key expansion to k10, then one
// decryption round per clock while the round key is unwound back to k0.

package aes_inv_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (= a^2 * a^4 * ... * a^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_inv_pkg::*;
    assign y = affine(gf_inv(a));
endmodule

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_inv_pkg::*;
    assign y = gf_inv(inv_affine(a));
endmodule

module aes_inv_cipher_128 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] din,
    output logic         busy,
    output logic         done,
    output logic [127:0] dout
);
    import aes_inv_pkg::*;

    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL, DONE} state_t;

    state_t       state;
    logic [127:0] blk;
    logic [127:0] round_key;
    logic [3:0]   rc;

    logic [127:0] shifted, subbed, added, mixed;
    logic [31:0]  w0, w1, w2, w3, iw1, iw2, iw3;
    logic [31:0]  sub_in, rot, sub_word, t;
    logic [127:0] fwd_key, inv_key;

    // Byte n sits at [127-8n -: 8]; byte r+4c lands in row r, column c.
    always_comb begin
        shifted = '0;
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
                shifted[127 - 8*(r + 4*c) -: 8] = blk[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
    end

    for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
        aes_inv_sbox u_inv_sbox (.a(shifted[8*g +: 8]), .y(subbed[8*g +: 8]));
    end

    assign added = subbed ^ round_key;

    always_comb begin
        mixed = '0;
        for (int unsigned c = 0; c < 4; c++)
            mixed[127 - 32*c -: 32] = inv_mix_col(added[127 - 32*c -: 32]);
    end

    assign {w0, w1, w2, w3} = round_key;
    assign iw3 = w3 ^ w2;
    assign iw2 = w2 ^ w1;
    assign iw1 = w1 ^ w0;

    // One SubWord serves both directions: forward uses w[3], inverse uses the new w'[3].
    assign sub_in = (state == KEXP) ? w3 : iw3;
    assign rot    = {sub_in[23:0], sub_in[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a(rot[8*g +: 8]), .y(sub_word[8*g +: 8]));
    end

    assign t       = sub_word ^ {rcon(rc), 24'h000000};
    assign fwd_key = {w0 ^ t, w1 ^ w0 ^ t, w2 ^ w1 ^ w0 ^ t, w3 ^ w2 ^ w1 ^ w0 ^ t};
    assign inv_key = {w0 ^ t, iw1, iw2, iw3};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            blk       <= '0;
            round_key <= '0;
            rc        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dout      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    blk       <= din;
                    round_key <= key;
                    rc        <= 4'd1;
                    busy      <= 1'b1;
                    state     <= KEXP;
                end
                KEXP: begin
                    round_key <= fwd_key;
                    if (rc == 4'd10) state <= INIT;
                    else             rc    <= rc + 4'd1;
                end
                INIT: begin
                    blk       <= blk ^ round_key;
                    round_key <= inv_key;
                    rc        <= 4'd9;
                    state     <= ROUND;
                end
                ROUND: begin
                    blk       <= mixed;
                    round_key <= inv_key;
                    rc        <= rc - 4'd1;
                    if (rc == 4'd1) state <= FINAL;
                end
                FINAL: begin
                    dout  <= added;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes_inv_cipher_128.md
AES_INV_CIPHER_128 -- requirements
Module: aes_inv_cipher_128

Interface
REQ-001 Parameters: none; the block is fixed to AES-128 (Nk=4, Nr=10).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request to decrypt; sampled only in IDLE.
REQ-005 key  input  128  cipher key (the forward key k0); sampled with start.
REQ-006 din  input  128  ciphertext block; sampled with start.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 done  output  1  one-cycle pulse; dout is valid in the same cycle.
REQ-009 dout  output  128  plaintext block; held until the next done pulse or reset.
REQ-010 Byte order SHALL follow FIPS-197: bits [127:120] carry byte 0 (state s[0][0]), and bytes fill columns in column-major order.

Function
REQ-011 FSM states SHALL be IDLE, KEXP, INIT, ROUND, FINAL and DONE.
REQ-012 IDLE, start=1: the block SHALL latch din into the state register and key into the round-key register, set round counter rc=1, and go to KEXP.
REQ-013 IDLE, start=0: the block SHALL hold all registers.
REQ-014 KEXP: the block SHALL run forward expansion, one round key per cycle (k_rc from k_rc-1, Rcon[rc]), for 10 cycles, ending with k10 in the round-key register.
REQ-015 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36 in the MSB of the word.
REQ-016 INIT (1 cycle): state SHALL become state ^ k10, the key register SHALL step back to k9, and the FSM SHALL go to ROUND with rc=9.
REQ-017 Inverse key step k_i to k_i-1: w'[3]=w[3]^w[2], w'[2]=w[2]^w[1], w'[1]=w[1]^w[0], w'[0]=w[0]^SubWord(RotWord(w'[3]))^Rcon[i].
REQ-018 ROUND (9 cycles, rc=9..1), per cycle: state SHALL become InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ k_rc), the key SHALL step to k_rc-1, and rc SHALL decrement.
REQ-019 After the rc=1 cycle the FSM SHALL go to FINAL.
REQ-020 FINAL (1 cycle): dout SHALL become InvSubBytes(InvShiftRows(state)) ^ k0, and the FSM SHALL go to DONE.
REQ-021 DONE (1 cycle): done=1, busy=0, then return to IDLE.
REQ-022 Latency: with start sampled at edge 0, done SHALL be high in the cycle after edge 22 (22 clocks); throughput SHALL be one block per 23 cycles.
REQ-023 Earliest next start: a start sampled in the cycle after DONE (back in IDLE) SHALL be accepted.
REQ-024 start while busy or in DONE SHALL be ignored and not queued; key and din changes while busy SHALL have no effect.
REQ-025 GF(2^8) arithmetic SHALL use the reduction polynomial x^8+x^4+x^3+x+1.
REQ-026 InvMixColumns SHALL use the coefficients 0e,0b,0d,09.
REQ-027 S-box and inverse S-box SHALL be combinational byte lookups instantiated as submodules; no multicycle paths.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, dout=0, rc=0, and clear the state and key registers, in any state, including mid-operation.
REQ-029 An operation interrupted by reset SHALL produce no done pulse.
REQ-030 With rst_n=0 and start=1 in the same cycle, reset SHALL win and start SHALL be ignored.

Verification
REQ-031 key=000102030405060708090a0b0c0d0e0f, din=69c4e0d86a7b0430d8cdb78070b4c55a, start 1 cycle -> done after 22 clocks, dout=00112233445566778899aabbccddeeff.
REQ-032 key=2b7e151628aed2a6abf7158809cf4f3c, din=3925841d02dc09fbdc118597196a0b32 -> dout=3243f6a8885a308d313198a2e0370734; the internal key register equals d014f9a8c9ee2589e13f0cc8b6630ca6 at INIT.
REQ-033 Two back-to-back blocks with start held high continuously -> second accepted the cycle after done; done pulses 23 cycles apart; both outputs correct.
REQ-034 Pulse start again at cycles 5 and 15 of an operation, with din changed -> ignored; the result equals the first block's plaintext.
REQ-035 Assert rst_n=0 at cycle 12, release, then start a new block -> no done for the aborted block; busy=0 and dout=0 after reset; the new block decrypts correctly.
REQ-036 Key all zeros, din=66e94bd4ef8a2c3b884cfa59ca342b2e -> dout=0 (all-zero plaintext).
